logic_op_sequencer: RTL and testbench

- Initiator/collector for the 4-bit AND/OR/XOR/XNOR logic unit.
- Accepts operand/opcode commands over a valid/ready handshake and drives the unit's A, B and Sel inputs.
- Waits a programmable settle time, samples the unit's Out and returns the result over a valid/ready response channel.
- Sweep mode runs all four operations on one operand pair and packs the results into one response.

---
 rtl/logic_op_sequencer.sv | 170 +++++++++++++++++
 tb/tb_logic_op_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: command/response sequencer for a 4-op logic unit.
// Accepts an operand pair and opcode, drives the unit's A/B/Sel, waits
// SETTLE_CYCLES per setting, samples lu_out and returns the result(s).
// Sweep mode runs AND, OR, XOR, XNOR back to back and packs four slots.
// Optional build macro LOGIC_OP_SEQUENCER_CHECK_EN adds an internal
// reference check of every captured result, flagged on the sticky err.
module logic_op_sequencer #(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 1   // legal range 1..15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic                 cmd_sweep,
   input  logic [WIDTH-1:0]     cmd_a,
   input  logic [WIDTH-1:0]     cmd_b,
   output logic [WIDTH-1:0]     lu_a,
   output logic [WIDTH-1:0]     lu_b,
   output logic [1:0]           lu_sel,
   input  logic [WIDTH-1:0]     lu_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [4*WIDTH-1:0]   rsp_data,
   output logic [2:0]           rsp_count,
   output logic                 busy,
   output logic                 err
);

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   // Counter value in the last settle cycle of one Sel setting.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     lu_a_q, lu_a_d;
   logic [WIDTH-1:0]     lu_b_q, lu_b_d;
   logic [1:0]           lu_sel_q, lu_sel_d;   // doubles as the op index
   logic                 sweep_q, sweep_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [4*WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [2:0]           rsp_count_q, rsp_count_d;
   logic [1:0]           slot;

   // Single ops always land in slot 0; sweeps use the op index.
   assign slot = sweep_q ? lu_sel_q : 2'd0;

`ifdef LOGIC_OP_SEQUENCER_CHECK_EN
   logic                 err_q, err_d;
   logic [WIDTH-1:0]     chk_exp;

   // Reference result for the operation currently driven on the unit.
   always_comb begin
      case (lu_sel_q)
         2'd0:    chk_exp = lu_a_q & lu_b_q;
         2'd1:    chk_exp = lu_a_q | lu_b_q;
         2'd2:    chk_exp = lu_a_q ^ lu_b_q;
         default: chk_exp = ~(lu_a_q ^ lu_b_q);
      endcase
   end
`endif

   // Next-state and datapath decisions for the IDLE/DRIVE/RESP sequence.
   always_comb begin
      // NOTE: every _d starts from its _q so no path through the case leaves a
      // variable unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      lu_a_d      = lu_a_q;
      lu_b_d      = lu_b_q;
      lu_sel_d    = lu_sel_q;
      sweep_d     = sweep_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_count_d = rsp_count_q;
`ifdef LOGIC_OP_SEQUENCER_CHECK_EN
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               lu_a_d     = cmd_a;
               lu_b_d     = cmd_b;
               sweep_d    = cmd_sweep;
               lu_sel_d   = cmd_sweep ? 2'd0 : cmd_op;
               cnt_d      = 4'd0;
               rsp_data_d = '0;
               state_d    = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q == SETTLE_LAST) begin
               rsp_data_d[int'(slot)*WIDTH +: WIDTH] = lu_out;
`ifdef LOGIC_OP_SEQUENCER_CHECK_EN
               if (lu_out != chk_exp) begin
                  err_d = 1'b1;
               end
`endif
               cnt_d = 4'd0;
               if (sweep_q && (lu_sel_q != 2'd3)) begin
                  lu_sel_d = lu_sel_q + 2'd1;
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_count_d = sweep_q ? 3'd4 : 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value regardless of statement order.
      if (!rst_n) begin
         state_q     <= IDLE;
         lu_a_q      <= '0;
         lu_b_q      <= '0;
         lu_sel_q    <= 2'd0;
         sweep_q     <= 1'b0;
         cnt_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_count_q <= 3'd0;
`ifdef LOGIC_OP_SEQUENCER_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         lu_a_q      <= lu_a_d;
         lu_b_q      <= lu_b_d;
         lu_sel_q    <= lu_sel_d;
         sweep_q     <= sweep_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_count_q <= rsp_count_d;
`ifdef LOGIC_OP_SEQUENCER_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign lu_a      = lu_a_q;
   assign lu_b      = lu_b_q;
   assign lu_sel    = lu_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_count = rsp_count_q;
`ifdef LOGIC_OP_SEQUENCER_CHECK_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_logic_op_sequencer.sv
// tb_logic_op_sequencer: two sequencer instances (SETTLE_CYCLES 1 and 3),
// each attached to a behavioural logic unit with an optional bit-flip fault.
// Directed scenarios plus randomized transactions checked against a
// transaction-level reference (expected slots, latency, Sel schedule).
module tb_logic_op_sequencer;

`ifdef LOGIC_OP_SEQUENCER_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic [1:0]        rst_n;
   logic [1:0]        cmd_valid, cmd_ready, cmd_sweep;
   logic [1:0][1:0]   cmd_op, lu_sel, flip_sel;
   logic [1:0][3:0]   cmd_a, cmd_b, lu_a, lu_b, lu_out, flip_mask;
   logic [1:0]        rsp_valid, rsp_ready, busy, err;
   logic [1:0][15:0]  rsp_data;
   logic [1:0][2:0]   rsp_count;
   bit   [1:0]        err_sticky;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic_op_sequencer #(.WIDTH(4), .SETTLE_CYCLES(g == 0 ? 1 : 3)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n[g]),
         .cmd_valid (cmd_valid[g]),
         .cmd_ready (cmd_ready[g]),
         .cmd_op    (cmd_op[g]),
         .cmd_sweep (cmd_sweep[g]),
         .cmd_a     (cmd_a[g]),
         .cmd_b     (cmd_b[g]),
         .lu_a      (lu_a[g]),
         .lu_b      (lu_b[g]),
         .lu_sel    (lu_sel[g]),
         .lu_out    (lu_out[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_data  (rsp_data[g]),
         .rsp_count (rsp_count[g]),
         .busy      (busy[g]),
         .err       (err[g])
      );
   end

   // Logic unit truth table: 0=AND, 1=OR, 2=XOR, 3=XNOR.
   function automatic logic [3:0] lu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   // Behavioural logic units, with an injectable fault on one Sel value.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         lu_out[i] = lu_fn(lu_a[i], lu_b[i], lu_sel[i]) ^
                     ((lu_sel[i] == flip_sel[i]) ? flip_mask[i] : 4'h0);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int settle_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // One full command/response transaction on instance d.
   task automatic run_txn(input int d, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op, input bit sweep, input int hold);
      int s = settle_of(d);
      int lat_exp = sweep ? 4 * s + 1 : s + 1;
      int j;
      int cap_cycle;
      bit flip_hit;
      logic [15:0] exp_data = 16'h0;
      logic [1:0]  exp_sel;
      logic [3:0]  fm;
      for (int k = 0; k < 4; k++) begin
         fm = (2'(k) == flip_sel[d]) ? flip_mask[d] : 4'h0;
         if (sweep) exp_data[k*4 +: 4] = lu_fn(a, b, 2'(k)) ^ fm;
      end
      if (!sweep) exp_data[3:0] = lu_fn(a, b, op) ^ ((op == flip_sel[d]) ? flip_mask[d] : 4'h0);
      flip_hit  = (flip_mask[d] != 4'h0) && (sweep || op == flip_sel[d]);
      cap_cycle = sweep ? (int'(flip_sel[d]) + 1) * s : s;

      @(negedge clk);
      check("cmd_ready_idle", cmd_ready[d], 1'b1);
      cmd_valid[d] = 1'b1;
      cmd_a[d]     = a;
      cmd_b[d]     = b;
      cmd_op[d]    = op;
      cmd_sweep[d] = sweep;
      rsp_ready[d] = (hold == 0);
      @(negedge clk);
      cmd_valid[d] = 1'b0;
      j = 1;
      while (!rsp_valid[d] && j <= 100) begin
         if (j < lat_exp) begin
            exp_sel = sweep ? 2'((j - 1) / s) : op;
            check("lu_sel", lu_sel[d], exp_sel);
            check("lu_a", lu_a[d], a);
            check("lu_b", lu_b[d], b);
            check("cmd_ready_busy", cmd_ready[d], 1'b0);
            check("busy", busy[d], 1'b1);
            check("err_drive", err[d],
                  CHECK_EN && (err_sticky[d] || (flip_hit && j > cap_cycle)));
         end
         @(negedge clk);
         j++;
      end
      if (!rsp_valid[d]) begin
         check("rsp_timeout", 1'b0, 1'b1);
         return;
      end
      if (flip_hit) err_sticky[d] = 1'b1;
      check("latency", j, lat_exp);
      check("rsp_data", rsp_data[d], exp_data);
      check("rsp_count", rsp_count[d], sweep ? 3'd4 : 3'd1);
      check("err_resp", err[d], CHECK_EN && err_sticky[d]);
      for (int h = 0; h < hold; h++) begin
         check("hold_valid", rsp_valid[d], 1'b1);
         check("hold_data", rsp_data[d], exp_data);
         check("hold_cmd_ready", cmd_ready[d], 1'b0);
         @(negedge clk);
      end
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      check("post_valid", rsp_valid[d], 1'b0);
      check("post_cmd_ready", cmd_ready[d], 1'b1);
      check("post_busy", busy[d], 1'b0);
      check("post_data_kept", rsp_data[d], exp_data);
      check("post_sel_kept", lu_sel[d], sweep ? 2'd3 : op);
   endtask

   task automatic reset_dut(input int d);
      @(negedge clk);
      rst_n[d] = 1'b0;
      @(negedge clk);
      rst_n[d] = 1'b1;
      err_sticky[d] = 1'b0;
   endtask

   initial begin
      bit saw_valid;
      int n;
      rst_n      = 2'b00;
      cmd_valid  = '0;
      cmd_sweep  = '0;
      cmd_op     = '0;
      cmd_a      = '0;
      cmd_b      = '0;
      rsp_ready  = '0;
      flip_sel   = '0;
      flip_mask  = '0;
      err_sticky = '0;
      repeat (2) @(negedge clk);
      rst_n = 2'b11;
      for (int d = 0; d < 2; d++) begin
         check("rst_cmd_ready", cmd_ready[d], 1'b1);
         check("rst_busy", busy[d], 1'b0);
         check("rst_valid", rsp_valid[d], 1'b0);
         check("rst_data", rsp_data[d], 16'h0);
         check("rst_count", rsp_count[d], 3'd0);
         check("rst_lu", {lu_a[d], lu_b[d], lu_sel[d]}, 10'h0);
         check("rst_err", err[d], 1'b0);
      end

      // Directed scenarios.
      run_txn(0, 4'b1100, 4'b1010, 2'd0, 1'b0, 0);   // 16'h0008
      run_txn(0, 4'b1100, 4'b1010, 2'd0, 1'b1, 0);   // 16'h96E8
      run_txn(0, 4'hF,    4'h0,    2'd3, 1'b0, 6);   // 16'h0000, held
      run_txn(1, 4'h5,    4'h3,    2'd0, 1'b1, 0);   // 16'h9671, latency 13

      // Reset in the middle of sweep index 2 aborts the command.
      @(negedge clk);
      cmd_valid[1] = 1'b1;
      cmd_sweep[1] = 1'b1;
      cmd_a[1]     = 4'hA;
      cmd_b[1]     = 4'h6;
      @(negedge clk);
      cmd_valid[1] = 1'b0;
      n = 0;
      while (lu_sel[1] != 2'd2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("reach_idx2", lu_sel[1], 2'd2);
      rst_n[1] = 1'b0;
      @(negedge clk);
      rst_n[1] = 1'b1;
      check("abort_busy", busy[1], 1'b0);
      check("abort_valid", rsp_valid[1], 1'b0);
      check("abort_sel", lu_sel[1], 2'd0);
      check("abort_cmd_ready", cmd_ready[1], 1'b1);
      saw_valid = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (rsp_valid[1]) saw_valid = 1'b1;
      end
      check("abort_no_rsp", saw_valid, 1'b0);

      // Fault on the XOR step: captured bit-exact, err reflects the checker.
      flip_sel[0]  = 2'd2;
      flip_mask[0] = 4'h1;
      run_txn(0, 4'b1100, 4'b1010, 2'd0, 1'b1, 0);   // slot 2 = 4'h7
      flip_mask[0] = 4'h0;
      run_txn(0, 4'h3, 4'h9, 2'd1, 1'b0, 1);         // err stays sticky
      reset_dut(0);
      check("err_cleared", err[0], 1'b0);

      // Randomized transactions on both instances.
      for (int t = 0; t < 40; t++) begin
         run_txn(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                 2'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
